// File: rtl/alu_pkg.sv
// Shared opcode constants, illegal-op predicate and sequencer state encoding
// for the ALU operation sequencer.
package alu_pkg;

  localparam logic [3:0] ALU_OP_ADD = 4'h0;
  localparam logic [3:0] ALU_OP_SUB = 4'h1;
  localparam logic [3:0] ALU_OP_MUL = 4'h2;
  localparam logic [3:0] ALU_OP_DIV = 4'h3;
  localparam logic [3:0] ALU_OP_SHR = 4'h4;
  localparam logic [3:0] ALU_OP_SHL = 4'h5;
  localparam logic [3:0] ALU_OP_ROR = 4'h6;
  localparam logic [3:0] ALU_OP_ROL = 4'h7;
  localparam logic [3:0] ALU_OP_AND = 4'h8;
  localparam logic [3:0] ALU_OP_OR  = 4'h9;
  localparam logic [3:0] ALU_OP_NEG = 4'hA;
  localparam logic [3:0] ALU_OP_NOT = 4'hB;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_EXEC = 2'd1,
    SEQ_RESP = 2'd2
  } seq_state_e;

  // Every code above NOT (1100..1111) is unassigned.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > ALU_OP_NOT;
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter that times the ALU latency; stops at zero and
// flags terminal count.
module alu_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: request handshake, latency wait, held response.
// Optional ALU_DIVZERO_CHECK_EN short-circuits divide-by-zero into an error response.
//
// state    | meaning
// SEQ_IDLE | waiting for a request, req_ready=1
// SEQ_EXEC | operands issued to ALU, counting down latency
// SEQ_RESP | result held, waiting for rsp_ready
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 2,
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic        alu_enable,
  input  logic [31:0] alu_zhi,
  input  logic [31:0] alu_zlow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_err,
  output logic        busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT)
                         ? ((MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT)
                         : ((DIV_LAT > ALU_LAT) ? DIV_LAT : ALU_LAT);
  localparam int CNT_W = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] ALU_LD = CNT_W'(ALU_LAT - 1);

  seq_state_e  state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] rsp_hi_q, rsp_hi_d, rsp_lo_q, rsp_lo_d;
  logic        rsp_err_q, rsp_err_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             accept;
  logic             div_zero;

  assign accept = req_valid && req_ready;

`ifdef ALU_DIVZERO_CHECK_EN
  assign div_zero = (req_op == ALU_OP_DIV) && (req_b == '0);
`else
  assign div_zero = 1'b0;
`endif

  alu_lat_counter #(.W(CNT_W)) u_lat_counter (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    ctrl_d       = ctrl_q;
    rsp_hi_d     = rsp_hi_q;
    rsp_lo_d     = rsp_lo_q;
    rsp_err_d    = rsp_err_q;
    cnt_load     = 1'b0;
    cnt_load_val = ALU_LD;
    case (state_q)
      SEQ_IDLE: begin
        if (accept) begin
          if (is_illegal_op(req_op) || div_zero) begin
            // Rejected ops never reach the ALU, so the issued operands keep their old values.
            state_d   = SEQ_RESP;
            rsp_err_d = 1'b1;
            rsp_hi_d  = '0;
            rsp_lo_d  = div_zero ? 32'hFFFF_FFFF : 32'h0;
          end else begin
            state_d  = SEQ_EXEC;
            a_d      = req_a;
            b_d      = req_b;
            ctrl_d   = req_op;
            cnt_load = 1'b1;
            case (req_op)
              ALU_OP_MUL: cnt_load_val = MUL_LD;
              ALU_OP_DIV: cnt_load_val = DIV_LD;
              default:    cnt_load_val = ALU_LD;
            endcase
          end
        end
      end
      SEQ_EXEC: begin
        if (cnt_zero) begin
          state_d   = SEQ_RESP;
          rsp_hi_d  = alu_zhi;
          rsp_lo_d  = alu_zlow;
          rsp_err_d = 1'b0;
        end
      end
      SEQ_RESP: begin
        if (rsp_ready) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= SEQ_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      ctrl_q    <= '0;
      rsp_hi_q  <= '0;
      rsp_lo_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ctrl_q    <= ctrl_d;
      rsp_hi_q  <= rsp_hi_d;
      rsp_lo_q  <= rsp_lo_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_ready  = (state_q == SEQ_IDLE) && !clr;
  assign alu_enable = (state_q == SEQ_EXEC);
  assign rsp_valid  = (state_q == SEQ_RESP);
  assign busy       = (state_q != SEQ_IDLE);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_hi     = rsp_hi_q;
  assign rsp_lo     = rsp_lo_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU driving zHI/zLOW.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 2;
  localparam int ALU_LAT = 1;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic        alu_enable;
  logic [31:0] alu_zhi, alu_zlow;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_hi, rsp_lo;
  logic        rsp_err, busy;

  always #5 clk = ~clk;

  alu_op_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_enable(alu_enable),
    .alu_zhi(alu_zhi), .alu_zlow(alu_zlow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;
  } rsp_t;

  function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] r;
    logic [5:0]  sh;
    r  = '0;
    sh = {1'b0, b[4:0]};
    case (op)
      ALU_OP_ADD: r[31:0] = a + b;
      ALU_OP_SUB: r[31:0] = a - b;
      ALU_OP_MUL: r = {32'h0, a} * {32'h0, b};
      ALU_OP_DIV: r = (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      ALU_OP_SHR: r[31:0] = a >> sh;
      ALU_OP_SHL: r[31:0] = a << sh;
      ALU_OP_ROR: r[31:0] = (a >> sh) | (a << (6'd32 - sh));
      ALU_OP_ROL: r[31:0] = (a << sh) | (a >> (6'd32 - sh));
      ALU_OP_AND: r[31:0] = a & b;
      ALU_OP_OR:  r[31:0] = a | b;
      ALU_OP_NEG: r[31:0] = -a;
      ALU_OP_NOT: r[31:0] = ~a;
      default:    r = 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
    return r;
  endfunction

  assign {alu_zhi, alu_zlow} = alu_model(alu_ctrl, alu_a, alu_b);

  function automatic int lat_of(input logic [3:0] op, input logic [31:0] b);
    if (op > 4'hB) return 0;
`ifdef ALU_DIVZERO_CHECK_EN
    if (op == 4'h3 && b == 32'h0) return 0;
`endif
    if (op == 4'h2) return MUL_LAT;
    if (op == 4'h3) return DIV_LAT;
    return ALU_LAT;
  endfunction

  function automatic rsp_t exp_of(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
    logic [63:0] r;
    if (op > 4'hB) return {1'b1, 32'h0, 32'h0};
`ifdef ALU_DIVZERO_CHECK_EN
    if (op == 4'h3 && b == 32'h0) return {1'b1, 32'h0, 32'hFFFF_FFFF};
`endif
    r = alu_model(op, a, b);
    return {1'b0, r[63:32], r[31:0]};
  endfunction

  rsp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_a = '0, last_b = '0;
  logic [3:0]  last_op = '0;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    int   lat, k, en_cnt;
    bit   seen;
    rsp_t exp_r;
    lat = lat_of(op, b);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    sb_q.push_back(exp_of(op, a, b));
    if (lat > 0) begin last_a = a; last_b = b; last_op = op; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
    en_cnt = 0; seen = 0; k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (alu_enable) en_cnt++;
      if (k == 1) begin
        chk("alu_a", alu_a, last_a);
        chk("alu_b", alu_b, last_b);
        chk("alu_ctrl", alu_ctrl, last_op);
      end
      if (rsp_valid) seen = 1;
    end
    if (!seen) begin
      chk("rsp_timeout", 0, 1);
      void'(sb_q.pop_front());
      return;
    end
    exp_r = sb_q.pop_front();
    chk("rsp_cycle", k, lat + 1);
    chk("en_cycles", en_cnt, lat);
    chk("busy_resp", busy, 1);
    chk("rsp_data", {rsp_err, rsp_hi, rsp_lo}, exp_r);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_op = ALU_OP_ADD; req_a = 32'h1234; req_b = 32'h5678;
      @(negedge clk);
      chk("bp_stable", {rsp_err, rsp_hi, rsp_lo}, exp_r);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_ready", req_ready, 0);
      chk("bp_en", alu_enable, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_drop", rsp_valid, 0);
    chk("ready_back", req_ready, 1);
  endtask

  initial begin
    clr = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_outs", |{alu_a, alu_b, alu_ctrl, alu_enable, rsp_valid, rsp_hi, rsp_lo,
                      rsp_err, busy}, 0);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", req_ready, 1);

    do_op(ALU_OP_ADD, 32'd5, 32'd7, 0);
    do_op(ALU_OP_MUL, 32'h0001_0000, 32'h0001_0000, 0);
    do_op(ALU_OP_SUB, 32'd100, 32'd30, 3);
    do_op(4'hC, 32'hAAAA_5555, 32'h1, 0);
    do_op(4'hF, 32'h1, 32'h2, 1);
    do_op(ALU_OP_DIV, 32'd9, 32'd0, 0);
    do_op(ALU_OP_DIV, 32'd100, 32'd7, 0);
    do_op(ALU_OP_ROL, 32'h8000_0001, 32'd4, 0);

    // Abandon a multiply partway through.
    @(negedge clk);
    req_valid = 1'b1; req_op = ALU_OP_MUL; req_a = 32'd3; req_b = 32'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_en", alu_enable, 1);
    @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    chk("mid_clr_ready", req_ready, 0);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("mid_outs", |{alu_a, alu_b, alu_ctrl, alu_enable, rsp_valid, rsp_hi, rsp_lo,
                      rsp_err, busy}, 0);
    chk("mid_ready", req_ready, 1);
    last_a = '0; last_b = '0; last_op = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", rsp_valid | alu_enable, 0);
    end
    do_op(ALU_OP_ADD, 32'd1, 32'd1, 0);

    for (int i = 0; i < 12; i++) begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      do_op(rop, ra, rb, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
